// File: rtl/fetch_ctrl_pkg.sv
// fetch_ctrl_pkg: PC update commands, fetch FSM states and the fetch timeout limit shared with pc
package fetch_ctrl_pkg;
  localparam logic [1:0] PC_INC_NORMAL = 2'b00;
  localparam logic [1:0] PC_INC_BRANCH = 2'b01;
  localparam logic [1:0] PC_INC_JUMP   = 2'b10;
  localparam logic [1:0] PC_INC_STOP   = 2'b11;
  localparam logic [3:0] WAIT_LIMIT    = 4'd15;
  typedef enum logic [2:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_RESOLVE,
    S_STEP,
    S_HALT
  } state_e;
endpackage

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: single-issue fetch/issue/retire sequencer driving the PC update command
module fetch_ctrl
  import fetch_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] current_pc,
  output logic [1:0]  pc_inc_type,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        flow_valid,
  input  logic [1:0]  flow_type,
  input  logic        halt_req,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_count
);
  state_e      state_q, state_d;
  logic [1:0]  pc_inc_q, pc_inc_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] retired_q, retired_d;
  logic [3:0]  timer_q, timer_d;
  logic        halt_pend_q, halt_pend_d;
  // Next state and registered outputs; pc_inc_type only leaves STOP for the STEP cycle
  always_comb begin
    state_d     = state_q;
    pc_inc_d    = PC_INC_STOP;
    req_d       = req_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    fault_d     = fault_q;
    retired_d   = retired_q;
    timer_d     = timer_q;
    halt_pend_d = halt_pend_q;
    case (state_q)
      S_FETCH: begin
        addr_d  = current_pc;
        req_d   = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT:
        if (imem_ack) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end else if (timer_q == WAIT_LIMIT) begin
          req_d    = 1'b0;
          fault_d  = 1'b1;
          halted_d = 1'b1;
          state_d  = S_HALT;
        end else timer_d = timer_q + 4'd1;
      S_ISSUE:
        if (instr_ready) begin
          valid_d = 1'b0;
          state_d = S_RESOLVE;
        end
      S_RESOLVE:
        if (flow_valid) begin
          pc_inc_d    = flow_type;
          retired_d   = retired_q + 32'd1;
          halt_pend_d = halt_req;
          state_d     = S_STEP;
        end
      S_STEP: begin
        halted_d = halt_pend_q;
        state_d  = halt_pend_q ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        req_d    = 1'b0;
        valid_d  = 1'b0;
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end
  // State register; clr overrides every transition
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= S_FETCH;
      pc_inc_q    <= PC_INC_STOP;
      req_q       <= 1'b0;
      addr_q      <= '0;
      instr_q     <= '0;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
      retired_q   <= '0;
      timer_q     <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_inc_q    <= pc_inc_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      instr_q     <= instr_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      fault_q     <= fault_d;
      retired_q   <= retired_d;
      timer_q     <= timer_d;
      halt_pend_q <= halt_pend_d;
    end
  end
  assign pc_inc_type   = pc_inc_q;
  assign imem_req      = req_q;
  assign imem_addr     = addr_q;
  assign instr         = instr_q;
  assign instr_valid   = valid_q;
  assign halted        = halted_q;
  assign fault         = fault_q;
  assign retired_count = retired_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl with a behavioural pc and instruction memory
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [31:0] current_pc;
  logic [1:0]  pc_inc_type;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        flow_valid = 1'b0;
  logic [1:0]  flow_type = 2'b00;
  logic        halt_req = 1'b0;
  logic        halted;
  logic        fault;
  logic [31:0] retired_count;
  logic        branch_taken = 1'b0;
  logic [31:0] target = '0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          sb_on = 1'b0;
  logic [31:0] q_addr[$];
  logic [31:0] q_instr[$];
  logic [1:0]  q_inc[$];
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_ret = '0;
  logic        req_prev = 1'b0;
  logic [1:0]  inc_prev = 2'b11;

  fetch_ctrl dut (
    .clk(clk), .clr(clr), .current_pc(current_pc), .pc_inc_type(pc_inc_type),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .flow_valid(flow_valid), .flow_type(flow_type), .halt_req(halt_req),
    .halted(halted), .fault(fault), .retired_count(retired_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Environment pc register driven by the command
  always @(posedge clk)
    if (clr) current_pc <= '0;
    else case (pc_inc_type)
      2'b00:   current_pc <= current_pc + 32'd4;
      2'b01:   current_pc <= branch_taken ? target : current_pc + 32'd4;
      2'b10:   current_pc <= target;
      default: current_pc <= current_pc;
    endcase

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops expectations whenever the DUT starts a fetch, hands off an instruction or issues a pc command
  always @(negedge clk) begin
    #1;
    if (sb_on) begin
      if (imem_req && !req_prev) begin
        if (q_addr.size() == 0) chk("unexpected_fetch", imem_addr, 32'hFFFF_FFFF);
        else chk("fetch_addr", imem_addr, q_addr.pop_front());
      end
      if (instr_valid && instr_ready) begin
        if (q_instr.size() == 0) chk("unexpected_instr", instr, 32'hFFFF_FFFF);
        else chk("instr", instr, q_instr.pop_front());
      end
      if (pc_inc_type != 2'b11) begin
        chk("inc_one_cycle", 32'(inc_prev), 32'd3);
        if (q_inc.size() == 0) chk("unexpected_inc", 32'(pc_inc_type), 32'd3);
        else chk("pc_inc", 32'(pc_inc_type), 32'(q_inc.pop_front()));
      end
    end
    req_prev = imem_req;
    inc_prev = pc_inc_type;
  end

  task automatic chk_reset();
    chk("rst_pc_inc", 32'(pc_inc_type), 32'd3);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_retired", retired_count, 32'd0);
  endtask

  task automatic do_reset();
    clr = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    flow_valid = 1'b0;
    halt_req = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset();
    clr = 1'b0;
    exp_pc = '0;
    exp_ret = '0;
    q_addr.delete();
    q_instr.delete();
    q_inc.delete();
    q_addr.push_back(32'd0);
    q_instr.push_back(mem_fn(32'd0));
  endtask

  task automatic wait_req();
    int n = 0;
    @(negedge clk);
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!imem_req) chk("fetch_timeout", 32'(imem_req), 32'd1);
  endtask

  // One instruction: ack after ad cycles, ready after rd, flow_valid after fd; reference computes the next fetch
  task automatic xact(input int ad, input int rd, input int fd, input logic [1:0] ft, input logic tk,
                      input logic [31:0] tgt, input logic hr, output int fc);
    wait_req();
    fc = cyc;
    repeat (ad) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = mem_fn(imem_addr);
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = $urandom;
    repeat (rd) begin
      flow_valid = 1'($urandom);
      flow_type = 2'($urandom);
      @(negedge clk);
    end
    flow_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    repeat (fd) @(negedge clk);
    flow_valid = 1'b1;
    flow_type = ft;
    branch_taken = tk;
    target = tgt;
    halt_req = hr;
    exp_ret = exp_ret + 32'd1;
    if (ft == 2'b00 || (ft == 2'b01 && !tk)) exp_pc = exp_pc + 32'd4;
    else if (ft != 2'b11) exp_pc = tgt;
    if (ft != 2'b11) q_inc.push_back(ft);
    if (!hr) begin
      q_addr.push_back(exp_pc);
      q_instr.push_back(mem_fn(exp_pc));
    end
    @(negedge clk);
    flow_valid = 1'b0;
    halt_req = 1'b0;
  endtask

  initial begin
    int f0, f1, f2, f3;
    logic seen;
    do_reset();
    sb_on = 1'b1;
    xact(0, 0, 0, 2'b00, 1'b0, 32'd0, 1'b0, f0);
    xact(0, 0, 0, 2'b00, 1'b0, 32'd0, 1'b0, f1);
    xact(0, 0, 0, 2'b00, 1'b0, 32'd0, 1'b0, f2);
    chk("retired3", retired_count, 32'd3);
    xact(0, 0, 0, 2'b10, 1'b0, 32'h0040_0000, 1'b0, f3);
    chk("latency01", 32'(f1 - f0), 32'd5);
    chk("latency12", 32'(f2 - f1), 32'd5);
    chk("latency23", 32'(f3 - f2), 32'd5);
    for (int i = 0; i < 40; i++)
      xact($urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3), 2'($urandom_range(0, 3)),
           1'($urandom), $urandom & 32'hFFFF_FFFC, 1'b0, f0);
    xact(1, 1, 1, 2'b00, 1'b0, 32'd0, 1'b1, f0);
    repeat (10) @(negedge clk);
    chk("rand_halted", 32'(halted), 32'd1);
    chk("rand_retired", retired_count, exp_ret);
    chk("rand_q_empty", 32'(q_addr.size() + q_instr.size() + q_inc.size()), 32'd0);
    sb_on = 1'b0;
    // Fetch timeout
    do_reset();
    wait_req();
    repeat (15) @(negedge clk);
    chk("to_req_held", 32'(imem_req), 32'd1);
    chk("to_no_fault_yet", 32'(fault), 32'd0);
    @(negedge clk);
    chk("to_fault", 32'(fault), 32'd1);
    chk("to_halted", 32'(halted), 32'd1);
    chk("to_req_drop", 32'(imem_req), 32'd0);
    imem_ack = 1'b1;
    instr_ready = 1'b1;
    flow_valid = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    flow_valid = 1'b0;
    chk("to_stay_halted", 32'(halted), 32'd1);
    chk("to_stay_req", 32'(imem_req), 32'd0);
    chk("to_stay_valid", 32'(instr_valid), 32'd0);
    chk("to_retired", retired_count, 32'd0);
    // Ack on the 16th WAIT cycle, stalled issue, halting taken branch
    do_reset();
    wait_req();
    repeat (15) @(negedge clk);
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    imem_ack = 1'b0;
    imem_rdata = '0;
    chk("ack16_fault", 32'(fault), 32'd0);
    chk("ack16_valid", 32'(instr_valid), 32'd1);
    chk("ack16_instr", instr, 32'hCAFE_0001);
    repeat (3) begin
      flow_valid = 1'b1;
      flow_type = 2'b10;
      @(negedge clk);
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_instr", instr, 32'hCAFE_0001);
      chk("stall_retired", retired_count, 32'd0);
    end
    flow_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("ready_drop", 32'(instr_valid), 32'd0);
    flow_valid = 1'b1;
    flow_type = 2'b01;
    branch_taken = 1'b1;
    target = 32'h0000_0100;
    halt_req = 1'b1;
    @(negedge clk);
    flow_valid = 1'b0;
    halt_req = 1'b0;
    chk("hb_step_inc", 32'(pc_inc_type), 32'd1);
    chk("hb_retired", retired_count, 32'd1);
    chk("hb_not_halted", 32'(halted), 32'd0);
    @(negedge clk);
    chk("hb_inc_stop", 32'(pc_inc_type), 32'd3);
    chk("hb_pc", current_pc, 32'h0000_0100);
    chk("hb_halted", 32'(halted), 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen |= imem_req;
    end
    chk("hb_no_req", 32'(seen), 32'd0);
    // clr in HALT, then clr mid-WAIT with ack asserted
    clr = 1'b1;
    @(negedge clk);
    chk_reset();
    clr = 1'b0;
    wait_req();
    chk("clr_fetch_addr", imem_addr, 32'd0);
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    clr = 1'b1;
    @(negedge clk);
    chk_reset();
    clr = 1'b0;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("clr_refetch_req", 32'(imem_req), 32'd1);
    chk("clr_refetch_addr", imem_addr, current_pc);
    chk("clr_refetch_pc0", imem_addr, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
